// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver.
// - Line synchronizer, then 3-sample majority vote per bit around mid-bit.
// - Frame format (data bits, parity, stop bits) is latched at start detection.
// - Completed frames go into a valid/ready output register with sticky overrun.
module uart_rx_cfg #(
  parameter int unsigned MAX_DATA    = 16,
  parameter int unsigned OVER_SAMPLE = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_tick,
  input  logic                          i_rx_en,
  input  logic                          i_rx_serial,
  input  logic [$clog2(MAX_DATA):0]     i_cfg_data_bits,
  input  logic [1:0]                    i_cfg_parity,
  input  logic                          i_cfg_stop2,
  input  logic                          i_ready,
  output logic [MAX_DATA-1:0]           o_data,
  output logic                          o_valid,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  output logic                          o_busy
);

  localparam int unsigned CW = $clog2(MAX_DATA) + 1;
  localparam int unsigned TW = $clog2(OVER_SAMPLE);

  localparam logic [TW-1:0] T_LO   = TW'(OVER_SAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVER_SAMPLE / 2);
  localparam logic [TW-1:0] T_HI   = TW'(OVER_SAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVER_SAMPLE - 1);

  localparam logic [CW-1:0] MIN_BITS = CW'(5);
  localparam logic [CW-1:0] MAX_BITS = CW'(MAX_DATA);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BRK_WAIT
  } state_t;

  // Synchronizer and receive datapath
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  state_t                 state_q, state_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          nbits_q, nbits_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   stop2_q, stop2_d;
  logic                   s0_q, s0_d;
  logic                   s1_q, s1_d;
  logic [MAX_DATA-1:0]    shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   serr_q, serr_d;
  logic                   done_q, done_d;

  // Output register
  logic [MAX_DATA-1:0]    data_o_q, data_o_d;
  logic                   valid_q, valid_d;
  logic                   perr_o_q, perr_o_d;
  logic                   ferr_o_q, ferr_o_d;
  logic                   ovr_q, ovr_d;

  logic                   maj;
  logic                   at_lo, at_mid, at_hi, at_wrap;
  logic [CW-1:0]          cfg_bits_c;
  logic                   xfer;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign maj     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign at_lo   = i_tick && (cnt_q == T_LO);
  assign at_mid  = i_tick && (cnt_q == T_MID);
  assign at_hi   = i_tick && (cnt_q == T_HI);
  assign at_wrap = i_tick && (cnt_q == T_LAST);

  assign cfg_bits_c = (i_cfg_data_bits < MIN_BITS) ? MIN_BITS :
                      (i_cfg_data_bits > MAX_BITS) ? MAX_BITS : i_cfg_data_bits;

  assign xfer = valid_q && i_ready;

  // Metastability synchronizer on the serial line, idles high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx_serial};
    end
  end

  // Receive state and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      done_q    <= done_d;
    end
  end

  // Bit timing, sampling and frame sequencing.
  // Majority decision and bit-boundary handling are separate ifs so that
  // OVER_SAMPLE=4 (decision tick == wrap tick) still sequences correctly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    serr_d    = serr_q;
    done_d    = 1'b0;

    if (state_q != IDLE && i_tick) begin
      cnt_d = at_wrap ? '0 : cnt_q + TW'(1);
    end
    if (at_lo) begin
      s0_d = rx_s;
    end
    if (at_mid) begin
      s1_d = rx_s;
    end

    unique case (state_q)
      IDLE: begin
        if (i_tick && i_rx_en && !rx_s) begin
          state_d   = START;
          cnt_d     = '0;
          idx_d     = '0;
          shift_d   = '0;
          perr_d    = 1'b0;
          serr_d    = 1'b0;
          nbits_d   = cfg_bits_c;
          par_en_d  = (i_cfg_parity == 2'b01) || (i_cfg_parity == 2'b10);
          par_odd_d = (i_cfg_parity == 2'b10);
          stop2_d   = i_cfg_stop2;
        end
      end
      START: begin
        if (at_hi && maj) begin
          state_d = IDLE;
        end else if (at_wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_hi) begin
          for (int unsigned i = 0; i < MAX_DATA; i++) begin
            if (idx_q == CW'(i)) begin
              shift_d[i] = maj;
            end
          end
        end
        if (at_wrap) begin
          if (idx_q == nbits_q - CW'(1)) begin
            state_d = par_en_q ? PARITY : STOP1;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      PARITY: begin
        if (at_hi) begin
          perr_d = (^shift_q) ^ maj ^ par_odd_q;
        end
        if (at_wrap) begin
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (at_hi) begin
          if (stop2_q) begin
            serr_d = !maj;
          end else begin
            done_d  = 1'b1;
            serr_d  = !maj;
            state_d = !maj ? BRK_WAIT : IDLE;
          end
        end
        if (at_wrap && stop2_q) begin
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (at_hi) begin
          done_d  = 1'b1;
          serr_d  = serr_q | !maj;
          state_d = (serr_q | !maj) ? BRK_WAIT : IDLE;
        end
      end
      BRK_WAIT: begin
        if (i_tick && rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Disable aborts any frame in flight without producing output
    if (state_q != IDLE && !i_rx_en) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  // Output register and handshake registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_o_q <= '0;
      valid_q  <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      data_o_q <= data_o_d;
      valid_q  <= valid_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
      ovr_q    <= ovr_d;
    end
  end

  // Load a completed frame when the slot is free or being drained, else flag overrun
  always_comb begin
    data_o_d = data_o_q;
    valid_d  = valid_q;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    ovr_d    = ovr_q;

    if (xfer) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done_q) begin
      if (!valid_q || i_ready) begin
        data_o_d = shift_q;
        perr_o_d = perr_q;
        ferr_o_d = serr_q;
        valid_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign o_data       = data_o_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_o_q;
  assign o_frame_err  = ferr_o_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != IDLE);

endmodule
